// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity
// selection constants and the default payload width.
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_tx_frame_if.sv
// System-side request bundle and serial-side status of the UART transmitter.
interface uart_tx_frame_if
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int PRESCALE_WIDTH = 6
);
   logic [DATA_WIDTH-1:0]     P_DATA;
   logic                      Data_Valid;
   logic                      parity_enable;
   logic                      parity_type;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic                      TX_OUT;
   logic                      busy;

   modport master (
      output P_DATA, Data_Valid, parity_enable, parity_type, prescale,
      input  TX_OUT, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, parity_enable, parity_type, prescale,
      output TX_OUT, busy
   );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter: runs 1..P while enabled and pulses bit_done on the
// last cycle of each bit. A prescale of 0 is treated as 1.
module uart_tx_bit_timer #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      enable,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [PRESCALE_WIDTH-1:0] edge_count,
   output logic                      bit_done
);

   logic [PRESCALE_WIDTH-1:0] p_eff;

   assign p_eff    = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
   assign bit_done = enable && (edge_count == p_eff);

   // Held at 1 while idle so the first cycle of the start bit is edge 1.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         edge_count <= '0;
      else if (!enable || bit_done)
         edge_count <= PRESCALE_WIDTH'(1);
      else
         edge_count <= edge_count + 1'b1;
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: latches a byte on request and serialises it LSB-first as
// start, data, optional parity and stop bits, each held for prescale cycles.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int PRESCALE_WIDTH = 6
) (
   input logic            CLK,
   input logic            RST,
   uart_tx_frame_if.slave bus
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   state_t                    state_q, state_d;
   logic [DATA_WIDTH-1:0]     shift_q, shift_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      par_en_q, parity_q;
   logic [PRESCALE_WIDTH-1:0] presc_q;
   logic                      tx_q, tx_d, busy_q, busy_d;
   logic                      accept, timer_en, bit_done;
   logic [PRESCALE_WIDTH-1:0] edge_count;

   assign accept   = (state_q == IDLE) && bus.Data_Valid;
   assign timer_en = (state_q != IDLE);

   uart_tx_bit_timer #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_timer (
      .CLK        (CLK),
      .RST        (RST),
      .enable     (timer_en),
      .prescale   (presc_q),
      .edge_count (edge_count),
      .bit_done   (bit_done)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE:
            if (bus.Data_Valid) begin
               state_d = START;
               shift_d = bus.P_DATA;
               idx_d   = '0;
            end
         START:
            if (bit_done) state_d = DATA;
         DATA:
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (idx_q == IDX_W'(DATA_WIDTH - 1))
                  state_d = par_en_q ? PARITY : STOP;
               else
                  idx_d = idx_q + 1'b1;
            end
         PARITY:
            if (bit_done) state_d = STOP;
         STOP:
            if (bit_done) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the line is registered.
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_q;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         par_en_q <= 1'b0;
         parity_q <= 1'b0;
         presc_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         if (accept) begin
            par_en_q <= bus.parity_enable;
            parity_q <= (^bus.P_DATA) ^ (bus.parity_type == PAR_ODD);
            presc_q  <= bus.prescale;
         end
      end
   end

   assign bus.TX_OUT = tx_q;
   assign bus.busy   = busy_q;

   a_edge_live: assert property (@(posedge CLK) disable iff (!RST)
      (state_q != IDLE) |-> (edge_count != '0));

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter, the outbound counterpart of the RX path's edge/bit counting and sampling chain.
- Accepts a parallel byte with a single-cycle valid strobe.
- Serialises it LSB-first as start, data, optional parity and stop bits on TX_OUT.
- Each bit is held for `prescale` CLK cycles, so it shares the oversampled clock and prescale setting used by RX.
- Sits between the system-side register/FIFO interface and the TX pin.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input (legal prescale 1..2^PRESCALE_WIDTH-1).

Ports:
- CLK  in  1  oversampling clock
- RST  in  1  asynchronous, active-low reset
- P_DATA  in  DATA_WIDTH  payload byte, sampled on accept
- Data_Valid  in  1  one-cycle request to send P_DATA
- parity_enable  in  1  1 = insert parity bit
- parity_type  in  1  0 = even, 1 = odd
- prescale  in  PRESCALE_WIDTH  CLK cycles per bit
- TX_OUT  out  1  serial line, idles high
- busy  out  1  frame in progress; requests ignored while high

Behaviour:
Reset and idle
- Reset is asynchronous on RST low. Resets to: TX_OUT=1, busy=0, state IDLE, all counters and latched registers 0.
- Reset mid-frame aborts the frame immediately: line returns to 1 with no partial stop bit.

Accept
- In IDLE, Data_Valid=1 at a rising edge is accepted. On that edge P_DATA, parity_enable, parity_type and prescale are latched.
- From the next cycle: TX_OUT=0 (start bit) and busy=1.
- Latched values are frozen for the whole frame; input changes mid-frame have no effect.
- Data_Valid while busy=1 is ignored and not queued.

Bit timing
- An internal edge counter runs 1..P, where P = latched prescale; prescale=0 is treated as 1.
- Each bit is driven for exactly P cycles; the bit advances when edge==P, and edge then wraps to 1.

FSM
- States: IDLE -> START -> DATA -> (PARITY if parity_enable) -> STOP -> IDLE.
- DATA outputs bit 0 first through bit DATA_WIDTH-1. A bit index of width clog2(DATA_WIDTH) counts 0..DATA_WIDTH-1 and leaves DATA at index DATA_WIDTH-1 with edge==P.
- Parity is computed once from the latched data: even = XOR of bits; odd = ~XOR.
- STOP drives 1 for P cycles, then the FSM enters IDLE and busy drops on the same edge.

Frame length and gap
- busy is high for exactly P*(DATA_WIDTH+2+parity_enable) cycles.
- A request may be accepted on the first cycle busy=0, so the minimum inter-frame idle is 1 cycle.

Outputs
- TX_OUT and busy are registered; no combinational path from inputs to outputs.

Decomposition:
- Package uart_pkg:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - parity type constants PAR_EVEN=0, PAR_ODD=1;
  - DATA_WIDTH default.
- Sub-module uart_tx_bit_timer: edge counter plus bit-done pulse. Inputs CLK, RST, enable, prescale. Outputs edge_count, bit_done.
- The top level holds the FSM, data shift register and parity logic.

Test Plan:
1. P_DATA=0xA5, prescale=8, parity on, even -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; each bit 8 cycles; busy high for 88 cycles.
2. Same as 1 with parity odd -> parity bit=1; all other bits unchanged; 88 cycles.
3. P_DATA=0x3C, prescale=4, parity off -> 0,0,0,1,1,1,1,0,0,1; busy high for 40 cycles; new Data_Valid accepted on first cycle busy=0; next start bit follows after 1 idle cycle.
4. Data_Valid pulsed with P_DATA=0xFF while busy during a 0x00 frame -> frame stays 0x00; no second frame follows.
5. RST low during DATA bit 3 -> TX_OUT=1 and busy=0 asynchronously; after release the next request (P_DATA=0x81, prescale=1, parity off) sends a 10-cycle frame.
6. prescale=0 with P_DATA=0x55 -> behaves as prescale=1: one cycle per bit, busy high for 10 cycles.
